// File: rtl/cache_opto_pkg.sv
// Shared definitions for the opto-channel sample cache: default widths,
// level width helper and the status bundle layout used by the register map.
package cache_opto_pkg;

  localparam int unsigned CACHE_OPTO_DW = 16;
  localparam int unsigned CACHE_OPTO_AW = 8;

  // Level must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int unsigned level_w(input int unsigned aw);
    return aw + 1;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic afull;
    logic full;
    logic empty;
  } status_t;

  localparam status_t STATUS_RESET = 5'b00001;

endpackage

// File: rtl/cache_opto_sdpram.sv
// Simple dual-port RAM with a registered read port; the array has no reset
// so it maps onto block RAM.
module cache_opto_sdpram #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cache_opto_fifo.sv
// FWFT cache buffer for opto samples: block RAM, prefetching head stage,
// registered level/threshold status and sticky error flags.
module cache_opto_fifo
  import cache_opto_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = CACHE_OPTO_DW,
  parameter int unsigned ADDR_WIDTH   = CACHE_OPTO_AW,
  parameter int unsigned AFULL_THRESH = 240
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_rd_ready,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_afull,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LW    = level_w(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]         ram_cnt, ram_cnt_nxt;
  logic [LW-1:0]         level, level_nxt;
  logic                  inflight, inflight_nxt;
  logic                  head_valid, head_valid_nxt;
  logic [DATA_WIDTH-1:0] head_data, ram_dout;
  status_t               status, status_nxt;
  logic                  wr_acc, pop, rd_en, load_head;

  cache_opto_sdpram #(
    .DW(DATA_WIDTH),
    .AW(ADDR_WIDTH)
  ) u_ram (
    .clk     (i_clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (i_wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (ram_dout)
  );

  // The RAM output register acts as a second prefetch slot behind the head:
  // a read issues whenever that slot will be free after this edge, which
  // keeps one word per clock flowing while popping back-to-back.
  always_comb begin
    wr_acc         = i_wr_en & ~status.full;
    pop            = head_valid & i_rd_ready;
    load_head      = inflight & (~head_valid | pop);
    rd_en          = (ram_cnt != '0) & (~inflight | ~head_valid | pop);
    inflight_nxt   = rd_en | (inflight & ~load_head);
    head_valid_nxt = load_head | (head_valid & ~pop);
    ram_cnt_nxt    = ram_cnt + LW'(wr_acc) - LW'(rd_en);
    level_nxt      = level + LW'(wr_acc) - LW'(pop);

    status_nxt           = status;
    status_nxt.full      = (level_nxt == LW'(DEPTH));
    status_nxt.empty     = (level_nxt == '0);
    status_nxt.afull     = (level_nxt >= LW'(AFULL_THRESH));
    status_nxt.overflow  = status.overflow | (i_wr_en & status.full);
    status_nxt.underflow = status.underflow | (i_rd_ready & ~head_valid & (level == '0));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_cnt    <= '0;
      level      <= '0;
      inflight   <= 1'b0;
      head_valid <= 1'b0;
      head_data  <= '0;
      status     <= STATUS_RESET;
    end else if (i_clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_cnt    <= '0;
      level      <= '0;
      inflight   <= 1'b0;
      head_valid <= 1'b0;
      status     <= STATUS_RESET;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_en)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      if (load_head) head_data <= ram_dout;
      ram_cnt    <= ram_cnt_nxt;
      level      <= level_nxt;
      inflight   <= inflight_nxt;
      head_valid <= head_valid_nxt;
      status     <= status_nxt;
    end
  end

  assign o_rd_valid  = head_valid;
  assign o_rd_data   = head_data;
  assign o_level     = level;
  assign o_full      = status.full;
  assign o_empty     = status.empty;
  assign o_afull     = status.afull;
  assign o_overflow  = status.overflow;
  assign o_underflow = status.underflow;

endmodule

// File: tb/tb_cache_opto_fifo.sv
// Scoreboard bench for cache_opto_fifo: stimulus queues expected words,
// a negedge monitor checks pops, level and status against its own model.
module tb_cache_opto_fifo;

  localparam int DEPTH = 256;
  localparam int AFT   = 240;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_clr = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [15:0] i_wr_data = '0;
  logic        o_rd_valid;
  logic [15:0] o_rd_data;
  logic        i_rd_ready = 1'b0;
  logic [8:0]  o_level;
  logic        o_full, o_empty, o_afull, o_overflow, o_underflow;

  int vectors = 0;
  int errors  = 0;
  int mlevel  = 0;
  bit movf = 1'b0, mudf = 1'b0;
  logic [15:0] q[$];

  cache_opto_fifo #(
    .DATA_WIDTH   (16),
    .ADDR_WIDTH   (8),
    .AFULL_THRESH (AFT)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clr       (i_clr),
    .i_wr_en     (i_wr_en),
    .i_wr_data   (i_wr_data),
    .o_rd_valid  (o_rd_valid),
    .o_rd_data   (o_rd_data),
    .i_rd_ready  (i_rd_ready),
    .o_level     (o_level),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_afull     (o_afull),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of inputs just after a rising edge; the next edge acts on them.
  task automatic step(input bit wr, input logic [15:0] d, input bit rdy, input bit clr);
    @(posedge clk);
    #1;
    i_wr_en    = wr;
    i_wr_data  = d;
    i_rd_ready = rdy;
    i_clr      = clr;
    if (wr && !clr && rst_n && mlevel != DEPTH) q.push_back(d);
  endtask

  always @(negedge clk) begin
    bit acc, pop;
    if (!rst_n) begin
      q.delete();
      mlevel = 0;
      movf = 1'b0;
      mudf = 1'b0;
    end else begin
      chk("level", 32'(o_level), 32'(mlevel));
      chk("full", 32'(o_full), 32'(mlevel == DEPTH));
      chk("empty", 32'(o_empty), 32'(mlevel == 0));
      chk("afull", 32'(o_afull), 32'(mlevel >= AFT));
      chk("overflow", 32'(o_overflow), 32'(movf));
      chk("underflow", 32'(o_underflow), 32'(mudf));
      if (o_rd_valid && i_rd_ready) begin
        if (q.size() == 0) chk("pop_with_no_word", 32'(o_rd_data), 32'hFFFF_FFFF);
        else               chk("pop_data", 32'(o_rd_data), 32'(q.pop_front()));
      end
      if (i_clr) begin
        q.delete();
        mlevel = 0;
        movf = 1'b0;
        mudf = 1'b0;
      end else begin
        acc = i_wr_en && (mlevel != DEPTH);
        pop = o_rd_valid && i_rd_ready;
        if (i_wr_en && mlevel == DEPTH) movf = 1'b1;
        if (i_rd_ready && !o_rd_valid && mlevel == 0) mudf = 1'b1;
        mlevel = mlevel + int'(acc) - int'(pop);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, 32'(o_rd_valid), 32'd0);
    chk({tag, "_data"}, 32'(o_rd_data), 32'd0);
    chk({tag, "_level"}, 32'(o_level), 32'd0);
    chk({tag, "_empty"}, 32'(o_empty), 32'd1);
    chk({tag, "_full"}, 32'(o_full), 32'd0);
    chk({tag, "_afull"}, 32'(o_afull), 32'd0);
    chk({tag, "_ovf"}, 32'(o_overflow), 32'd0);
    chk({tag, "_udf"}, 32'(o_underflow), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("rst");

    // Single word: valid appears two edges after the accepting edge
    step(1, 16'h1234, 0, 0);
    step(0, 16'h0000, 0, 0);
    @(negedge clk); chk("lat_e1_valid", 32'(o_rd_valid), 32'd0);
    step(0, 16'h0000, 0, 0);
    @(negedge clk); chk("lat_e2_valid", 32'(o_rd_valid), 32'd0);
    step(0, 16'h0000, 0, 0);
    @(negedge clk);
    chk("lat_e3_valid", 32'(o_rd_valid), 32'd1);
    chk("lat_e3_data", 32'(o_rd_data), 32'h1234);
    chk("lat_e3_level", 32'(o_level), 32'd1);
    step(0, 16'h0000, 1, 0);
    step(0, 16'h0000, 0, 0);
    @(negedge clk);
    chk("single_empty", 32'(o_empty), 32'd1);

    // Fill to full, then overflow and a write-while-full alongside a pop
    for (int i = 0; i < DEPTH; i++) step(1, 16'(i), 0, 0);
    step(0, 16'h0000, 0, 0);
    @(negedge clk);
    chk("fill_full", 32'(o_full), 32'd1);
    chk("fill_afull", 32'(o_afull), 32'd1);
    chk("fill_head", 32'(o_rd_data), 32'h0000);
    step(1, 16'hDEAD, 0, 0);
    step(0, 16'h0000, 0, 0);
    @(negedge clk);
    chk("ovf_level", 32'(o_level), 32'd256);
    chk("ovf_flag", 32'(o_overflow), 32'd1);
    step(1, 16'hBEEF, 1, 0);
    step(0, 16'h0000, 0, 0);
    @(negedge clk);
    chk("full_pop_level", 32'(o_level), 32'd255);
    chk("full_pop_deassert", 32'(o_full), 32'd0);

    // Drain past empty so ready is seen with nothing to offer
    for (int i = 0; i < 260; i++) step(0, 16'h0000, 1, 0);
    step(0, 16'h0000, 0, 0);
    @(negedge clk);
    chk("drain_empty", 32'(o_empty), 32'd1);
    chk("udf_flag", 32'(o_underflow), 32'd1);

    // Clear together with a write
    step(1, 16'h7777, 0, 1);
    step(0, 16'h0000, 0, 0);
    @(negedge clk);
    chk("clr_level", 32'(o_level), 32'd0);
    chk("clr_ovf", 32'(o_overflow), 32'd0);
    chk("clr_udf", 32'(o_underflow), 32'd0);
    chk("clr_valid", 32'(o_rd_valid), 32'd0);

    // Steady streaming at level 5 with pointer wrap
    for (int i = 0; i < 5; i++) step(1, 16'(16'h4000 + i), 0, 0);
    repeat (3) step(0, 16'h0000, 0, 0);
    for (int i = 0; i < 1000; i++) begin
      step(1, 16'(16'h5000 + i), 1, 0);
      @(negedge clk);
      chk("stream_level", 32'(o_level), 32'd5);
      chk("stream_valid", 32'(o_rd_valid), 32'd1);
    end
    for (int i = 0; i < 5; i++) step(0, 16'h0000, 1, 0);
    step(0, 16'h0000, 0, 0);
    @(negedge clk);
    chk("stream_empty", 32'(o_empty), 32'd1);

    // Mixed write/ready pattern with the queue doing the checking
    for (int i = 0; i < 600; i++)
      step((i % 3) != 2, 16'(i * 37 + 5), ((i % 4) == 0) || ((i % 7) == 3), 0);
    step(0, 16'h0000, 0, 1);

    // Asynchronous reset while holding 10 words with a valid head
    for (int i = 0; i < 10; i++) step(1, 16'(16'h6000 + i), 0, 0);
    repeat (4) step(0, 16'h0000, 0, 0);
    @(negedge clk);
    chk("pre_rst_level", 32'(o_level), 32'd10);
    chk("pre_rst_valid", 32'(o_rd_valid), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_values("async");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step(1, 16'hA5A5, 0, 0);
    step(1, 16'h5A5A, 0, 0);
    step(0, 16'h0000, 0, 0);
    step(0, 16'h0000, 0, 0);
    @(negedge clk);
    chk("post_rst_head", 32'(o_rd_data), 32'hA5A5);
    step(0, 16'h0000, 1, 0);
    step(0, 16'h0000, 1, 0);
    step(0, 16'h0000, 0, 0);
    step(0, 16'h0000, 0, 0);
    @(negedge clk);
    chk("post_rst_empty", 32'(o_empty), 32'd1);
    chk("sb_leftover", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
